ps_gesture_detect: RTL and testbench

//  Consumes the three 16-bit proximity readings (PS1/PS2/PS3_DATA) and the I2C_LO0P loop-complete

---
 rtl/ps_gesture_pkg.sv | 51 +++++
 rtl/ps_chan_filt.sv | 58 +++++
 rtl/ps_gesture_detect.sv | 209 ++++++++++++++++++++
 tb/tb_ps_gesture_detect.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps_gesture_pkg.sv
// Shared gesture codes, FSM states and channel-index helpers
// for the Si114x proximity gesture detector.
package ps_gesture_pkg;

    localparam logic [2:0] G_NONE  = 3'd0;
    localparam logic [2:0] G_LR    = 3'd1;
    localparam logic [2:0] G_RL    = 3'd2;
    localparam logic [2:0] G_DOWN  = 3'd3;
    localparam logic [2:0] G_UP    = 3'd4;
    localparam logic [2:0] G_HOVER = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TRACK  = 2'd1,
        S_REPORT = 2'd2,
        S_HOLD   = 2'd3
    } gst_state_t;

    // Channel index 1..3 of the lowest set bit (0 when none set)
    function automatic logic [1:0] low_idx(input logic [2:0] v);
        logic [1:0] r;
        r = 2'd0;
        if (v[0])      r = 2'd1;
        else if (v[1]) r = 2'd2;
        else if (v[2]) r = 2'd3;
        return r;
    endfunction

    // Channel index 1..3 of the highest set bit (0 when none set)
    function automatic logic [1:0] high_idx(input logic [2:0] v);
        logic [1:0] r;
        r = 2'd0;
        if (v[2])      r = 2'd3;
        else if (v[1]) r = 2'd2;
        else if (v[0]) r = 2'd1;
        return r;
    endfunction

    // Swipe direction from the first and last channels that went NEAR
    function automatic logic [2:0] classify(input logic [1:0] first,
                                            input logic [1:0] last);
        logic [2:0] c;
        c = G_NONE;
        if (first == 2'd1 && last == 2'd2)      c = G_LR;
        else if (first == 2'd2 && last == 2'd1) c = G_RL;
        else if (first == 2'd3)                 c = G_DOWN;
        else if (last == 2'd3)                  c = G_UP;
        return c;
    endfunction

endpackage

// File: rtl/ps_chan_filt.sv
// One proximity channel: first-order IIR filter with clamp,
// followed by a NEAR/FAR hysteresis flag updated one cycle later.
module ps_chan_filt #(
    parameter int          AVG_SHIFT = 2,
    parameter logic [15:0] TH_ON     = 16'd2000,
    parameter logic [15:0] TH_OFF    = 16'd1500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stb,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        near
);

    logic               loaded;
    logic               stb_q;
    logic signed [16:0] diff;
    logic signed [16:0] step;
    logic signed [17:0] sum;
    logic        [15:0] f_next;

    // F + (X-F)>>>AVG_SHIFT, saturated to the unsigned 16-bit range
    always_comb begin
        diff = $signed({1'b0, din}) - $signed({1'b0, dout});
        step = diff >>> AVG_SHIFT;
        sum  = $signed({2'b00, dout}) + $signed({step[16], step});
        if (sum[17])      f_next = 16'd0;
        else if (sum[16]) f_next = 16'hFFFF;
        else              f_next = sum[15:0];
    end

    // Filter state; the first sample after reset seeds it directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout   <= 16'd0;
            loaded <= 1'b0;
        end else if (stb) begin
            dout   <= loaded ? f_next : din;
            loaded <= 1'b1;
        end
    end

    // Hysteresis flag follows the freshly updated filter value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_q <= 1'b0;
            near  <= 1'b0;
        end else begin
            stb_q <= stb;
            if (stb_q) begin
                if (dout >= TH_ON)      near <= 1'b1;
                else if (dout < TH_OFF) near <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ps_gesture_detect.sv
// Proximity gesture detector: toggle synchroniser, sample capture,
// three channel filters and the swipe/hover classification FSM.
module ps_gesture_detect
    import ps_gesture_pkg::*;
#(
    parameter int          AVG_SHIFT   = 2,
    parameter logic [15:0] TH_ON       = 16'd2000,
    parameter logic [15:0] TH_OFF      = 16'd1500,
    parameter int          TIMEOUT_SMP = 32,
    parameter int          HOVER_SMP   = 64
) (
    input  logic        CLK_50,
    input  logic        RESET_N,
    input  logic        SAMPLE_TGL,
    input  logic [15:0] PS1_DATA,
    input  logic [15:0] PS2_DATA,
    input  logic [15:0] PS3_DATA,
    output logic [15:0] PS1_FILT,
    output logic [15:0] PS2_FILT,
    output logic [15:0] PS3_FILT,
    output logic [2:0]  NEAR,
    output logic        SAMPLE_STB,
    output logic        GESTURE_VALID,
    output logic [2:0]  GESTURE_CODE,
    output logic [15:0] SAMPLE_CNT
);

    logic        tgl_s1, tgl_s2, tgl_s3;
    logic        tgl_edge;
    logic [15:0] cap1, cap2, cap3;
    logic        stb_d1, stb_d2;
    logic        smp;

    gst_state_t  state, state_n;
    logic [1:0]  first, first_n;
    logic [1:0]  last, last_n, last_t;
    logic [2:0]  prev_near, prev_n;
    logic [2:0]  rise;
    logic [15:0] tcnt, tcnt_n, t_inc;
    logic [15:0] hcnt, hcnt_n, h_inc;
    logic [2:0]  code_n, g;
    logic        gv_n;

    assign tgl_edge = tgl_s2 ^ tgl_s3;
    assign smp      = stb_d2;

    // Two-flop synchroniser plus history flop for edge detection
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            tgl_s1 <= 1'b0;
            tgl_s2 <= 1'b0;
            tgl_s3 <= 1'b0;
        end else begin
            tgl_s1 <= SAMPLE_TGL;
            tgl_s2 <= tgl_s1;
            tgl_s3 <= tgl_s2;
        end
    end

    // Capture the stable PS set, pulse the strobe and count samples
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            SAMPLE_STB <= 1'b0;
            SAMPLE_CNT <= 16'd0;
            cap1       <= 16'd0;
            cap2       <= 16'd0;
            cap3       <= 16'd0;
        end else begin
            SAMPLE_STB <= tgl_edge;
            if (tgl_edge) begin
                SAMPLE_CNT <= SAMPLE_CNT + 16'd1;
                cap1       <= PS1_DATA;
                cap2       <= PS2_DATA;
                cap3       <= PS3_DATA;
            end
        end
    end

    // Strobe delay line aligning the FSM with settled NEAR flags
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            stb_d1 <= 1'b0;
            stb_d2 <= 1'b0;
        end else begin
            stb_d1 <= SAMPLE_STB;
            stb_d2 <= stb_d1;
        end
    end

    ps_chan_filt #(
        .AVG_SHIFT (AVG_SHIFT),
        .TH_ON     (TH_ON),
        .TH_OFF    (TH_OFF)
    ) u_ch1 (
        .clk   (CLK_50),
        .rst_n (RESET_N),
        .stb   (SAMPLE_STB),
        .din   (cap1),
        .dout  (PS1_FILT),
        .near  (NEAR[0])
    );

    ps_chan_filt #(
        .AVG_SHIFT (AVG_SHIFT),
        .TH_ON     (TH_ON),
        .TH_OFF    (TH_OFF)
    ) u_ch2 (
        .clk   (CLK_50),
        .rst_n (RESET_N),
        .stb   (SAMPLE_STB),
        .din   (cap2),
        .dout  (PS2_FILT),
        .near  (NEAR[1])
    );

    ps_chan_filt #(
        .AVG_SHIFT (AVG_SHIFT),
        .TH_ON     (TH_ON),
        .TH_OFF    (TH_OFF)
    ) u_ch3 (
        .clk   (CLK_50),
        .rst_n (RESET_N),
        .stb   (SAMPLE_STB),
        .din   (cap3),
        .dout  (PS3_FILT),
        .near  (NEAR[2])
    );

    // Gesture FSM state and track bookkeeping registers
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= S_IDLE;
            first         <= 2'd0;
            last          <= 2'd0;
            prev_near     <= 3'd0;
            tcnt          <= 16'd0;
            hcnt          <= 16'd0;
            GESTURE_VALID <= 1'b0;
            GESTURE_CODE  <= G_NONE;
        end else begin
            state         <= state_n;
            first         <= first_n;
            last          <= last_n;
            prev_near     <= prev_n;
            tcnt          <= tcnt_n;
            hcnt          <= hcnt_n;
            GESTURE_VALID <= gv_n;
            GESTURE_CODE  <= code_n;
        end
    end

    // Next-state logic; the timeout only ages while not all three
    // channels are NEAR, so a hover can outlast the swipe window
    always_comb begin
        state_n = state;
        first_n = first;
        last_n  = last;
        prev_n  = prev_near;
        tcnt_n  = tcnt;
        hcnt_n  = hcnt;
        code_n  = GESTURE_CODE;
        gv_n    = 1'b0;
        rise    = NEAR & ~prev_near;
        t_inc   = tcnt + 16'd1;
        h_inc   = (NEAR == 3'b111) ? hcnt + 16'd1 : 16'd0;
        last_t  = (rise != 3'd0) ? high_idx(rise) : last;
        g       = classify(first, last_t);
        if (smp) prev_n = NEAR;
        unique case (state)
            S_IDLE: begin
                if (smp && NEAR != 3'd0) begin
                    state_n = S_TRACK;
                    first_n = low_idx(NEAR);
                    last_n  = low_idx(NEAR);
                    tcnt_n  = 16'd0;
                    hcnt_n  = (NEAR == 3'b111) ? 16'd1 : 16'd0;
                end
            end
            S_TRACK: begin
                if (smp) begin
                    last_n = last_t;
                    if (NEAR == 3'd0) begin
                        state_n = S_REPORT;
                        if (g != G_NONE) begin
                            gv_n   = 1'b1;
                            code_n = g;
                        end
                    end else if (h_inc == 16'(HOVER_SMP)) begin
                        state_n = S_REPORT;
                        gv_n    = 1'b1;
                        code_n  = G_HOVER;
                    end else if (NEAR != 3'b111 &&
                                 t_inc == 16'(TIMEOUT_SMP)) begin
                        state_n = S_HOLD;
                    end else begin
                        hcnt_n = h_inc;
                        if (NEAR != 3'b111) tcnt_n = t_inc;
                    end
                end
            end
            S_REPORT: state_n = S_HOLD;
            S_HOLD: begin
                if (smp && NEAR == 3'd0) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ps_gesture_detect.sv
// Self-checking bench for ps_gesture_detect: constant vector table,
// hand sequences for gestures/reset, and a random run vs a model.
module tb_ps_gesture_detect;

    localparam int AVG_SHIFT = 2;
    localparam int TH_ON     = 2000;
    localparam int TH_OFF    = 1500;
    localparam int TIMEOUT   = 32;
    localparam int HOVER     = 64;
    localparam int SPACING   = 60;

    logic        CLK_50 = 1'b0;
    logic        RESET_N = 1'b0;
    logic        SAMPLE_TGL = 1'b0;
    logic [15:0] PS1_DATA = 16'd0;
    logic [15:0] PS2_DATA = 16'd0;
    logic [15:0] PS3_DATA = 16'd0;
    logic [15:0] PS1_FILT, PS2_FILT, PS3_FILT;
    logic [2:0]  NEAR;
    logic        SAMPLE_STB;
    logic        GESTURE_VALID;
    logic [2:0]  GESTURE_CODE;
    logic [15:0] SAMPLE_CNT;

    always #10 CLK_50 = ~CLK_50;

    ps_gesture_detect #(
        .AVG_SHIFT   (AVG_SHIFT),
        .TH_ON       (16'(TH_ON)),
        .TH_OFF      (16'(TH_OFF)),
        .TIMEOUT_SMP (TIMEOUT),
        .HOVER_SMP   (HOVER)
    ) dut (
        .CLK_50        (CLK_50),
        .RESET_N       (RESET_N),
        .SAMPLE_TGL    (SAMPLE_TGL),
        .PS1_DATA      (PS1_DATA),
        .PS2_DATA      (PS2_DATA),
        .PS3_DATA      (PS3_DATA),
        .PS1_FILT      (PS1_FILT),
        .PS2_FILT      (PS2_FILT),
        .PS3_FILT      (PS3_FILT),
        .NEAR          (NEAR),
        .SAMPLE_STB    (SAMPLE_STB),
        .GESTURE_VALID (GESTURE_VALID),
        .GESTURE_CODE  (GESTURE_CODE),
        .SAMPLE_CNT    (SAMPLE_CNT)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int mf[3];
    bit mload;
    bit mnear[3];
    int mcnt;
    int mmode;      // 0 idle, 1 tracking, 2 blocked until all far
    int trk[$];     // NEAR vectors of the current track
    int mlast_code;

    function automatic int fdiv(input int d, input int s);
        int p;
        p = 1 << s;
        if (d >= 0) return d / p;
        return -((-d + p - 1) / p);
    endfunction

    function automatic int lo_ch(input int v);
        for (int i = 0; i < 3; i++) if (v & (1 << i)) return i + 1;
        return 0;
    endfunction

    function automatic int hi_ch(input int v);
        for (int i = 2; i >= 0; i--) if (v & (1 << i)) return i + 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mf[i] = 0;
            mnear[i] = 0;
        end
        mload = 0;
        mcnt = 0;
        mmode = 0;
        trk.delete();
        mlast_code = 0;
    endtask

    task automatic model_sample(input int x1, input int x2, input int x3,
                                output int ep, output int ec);
        int x[3];
        int nv, fst, lst, run7, stall, code;
        x[0] = x1; x[1] = x2; x[2] = x3;
        for (int i = 0; i < 3; i++) begin
            if (!mload) mf[i] = x[i];
            else mf[i] = mf[i] + fdiv(x[i] - mf[i], AVG_SHIFT);
            if (mf[i] < 0) mf[i] = 0;
            if (mf[i] > 65535) mf[i] = 65535;
            if (mf[i] >= TH_ON) mnear[i] = 1;
            else if (mf[i] < TH_OFF) mnear[i] = 0;
        end
        mload = 1;
        mcnt = (mcnt + 1) % 65536;
        nv = mnear[0] + 2 * mnear[1] + 4 * mnear[2];
        ep = 0;
        ec = 0;
        if (mmode == 0) begin
            if (nv != 0) begin
                trk.delete();
                trk.push_back(nv);
                mmode = 1;
            end
        end else if (mmode == 1) begin
            trk.push_back(nv);
            fst = lo_ch(trk[0]);
            lst = fst;
            for (int i = 1; i < trk.size(); i++)
                if ((trk[i] & ~trk[i-1]) != 0)
                    lst = hi_ch(trk[i] & ~trk[i-1]);
            run7 = 0;
            for (int i = trk.size() - 1; i >= 0 && trk[i] == 7; i--)
                run7++;
            stall = 0;
            for (int i = 1; i < trk.size(); i++)
                if (trk[i] != 7) stall++;
            if (nv == 0) begin
                code = 0;
                if (fst == 1 && lst == 2) code = 1;
                else if (fst == 2 && lst == 1) code = 2;
                else if (fst == 3) code = 3;
                else if (lst == 3) code = 4;
                if (code != 0) begin
                    ep = 1;
                    ec = code;
                end
                mmode = 2;
            end else if (run7 == HOVER) begin
                ep = 1;
                ec = 5;
                mmode = 2;
            end else if (nv != 7 && stall == TIMEOUT) begin
                mmode = 2;
            end
        end else begin
            if (nv == 0) mmode = 0;
        end
        if (ep) mlast_code = ec;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge CLK_50);
        #1;
        RESET_N = 1'b0;
        SAMPLE_TGL = 1'b0;
        PS1_DATA = 16'd0;
        PS2_DATA = 16'd0;
        PS3_DATA = 16'd0;
        @(negedge CLK_50);
        chk("rst_filt", {PS1_FILT, PS2_FILT, PS3_FILT}, 64'd0);
        chk("rst_misc", {NEAR, SAMPLE_STB, GESTURE_VALID, GESTURE_CODE,
                         SAMPLE_CNT}, 64'd0);
        model_reset();
        repeat (2) @(posedge CLK_50);
        #1;
        RESET_N = 1'b1;
        repeat (3) @(posedge CLK_50);
    endtask

    task automatic do_sample(input int a, input int b, input int c,
                             output int gp, output int gc);
        int stbn, stbpos, gvn, gvpos, gcode, ep, ec, nv;
        @(posedge CLK_50);
        #1;
        PS1_DATA = 16'(a);
        PS2_DATA = 16'(b);
        PS3_DATA = 16'(c);
        SAMPLE_TGL = ~SAMPLE_TGL;
        stbn = 0; stbpos = 0; gvn = 0; gvpos = 0; gcode = 0;
        @(posedge CLK_50);
        for (int k = 1; k <= SPACING; k++) begin
            @(negedge CLK_50);
            if (SAMPLE_STB) begin
                stbn++;
                stbpos = k;
            end
            if (GESTURE_VALID) begin
                gvn++;
                gvpos = k;
                gcode = GESTURE_CODE;
            end
        end
        model_sample(a, b, c, ep, ec);
        nv = mnear[0] + 2 * mnear[1] + 4 * mnear[2];
        chk("stb_timing", stbn * 256 + stbpos, 256 + 3);
        chk("filt1", PS1_FILT, mf[0]);
        chk("filt2", PS2_FILT, mf[1]);
        chk("filt3", PS3_FILT, mf[2]);
        chk("near", NEAR, nv);
        chk("sample_cnt", SAMPLE_CNT, mcnt);
        chk("gesture", gvn * 256 + gvpos * 16 + gcode,
            ep ? 256 + 6 * 16 + ec : 0);
        chk("code_hold", GESTURE_CODE, mlast_code);
        gp = gvn;
        gc = gcode;
    endtask

    task automatic run_seg(input int n, input int a, input int b,
                           input int c, inout int pulses, inout int code);
        int gp, gc;
        for (int i = 0; i < n; i++) begin
            do_sample(a, b, c, gp, gc);
            pulses += gp;
            if (gp != 0) code = gc;
        end
    endtask

    task automatic swipe(input bit mirror, output int pulses,
                         output int code);
        int hi1, hi2;
        hi1 = mirror ? 0 : 4000;
        hi2 = mirror ? 4000 : 0;
        pulses = 0;
        code = 0;
        run_seg(4, hi1, hi2, 0, pulses, code);
        run_seg(4, 4000, 4000, 0, pulses, code);
        run_seg(6, hi2, hi1, 0, pulses, code);
        run_seg(8, 0, 0, 0, pulses, code);
    endtask

    typedef struct {
        int x1;
        int exp_f1;
        bit exp_n1;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int gp, gc, pulses, code;
        int mask, len, v[3];

        tbl[0] = '{0,    0,    1'b0};
        tbl[1] = '{4000, 1000, 1'b0};
        tbl[2] = '{4000, 1750, 1'b0};
        tbl[3] = '{4000, 2312, 1'b1};
        tbl[4] = '{1464, 2100, 1'b1};
        tbl[5] = '{100,  1600, 1'b1};
        tbl[6] = '{800,  1400, 1'b0};

        model_reset();

        // Reset and first sample loads the filters directly
        do_reset();
        do_sample(1000, 1000, 1000, gp, gc);
        chk("t1_filt", {PS1_FILT, PS2_FILT, PS3_FILT},
            {16'd1000, 16'd1000, 16'd1000});
        chk("t1_near", NEAR, 3'b000);

        // Filter step response and hysteresis from constant table
        do_reset();
        for (int i = 0; i < 7; i++) begin
            do_sample(tbl[i].x1, 0, 0, gp, gc);
            chk("tbl_filt1", PS1_FILT, tbl[i].exp_f1);
            chk("tbl_near1", NEAR[0], tbl[i].exp_n1);
        end

        // Swipes in both directions
        do_reset();
        swipe(1'b0, pulses, code);
        chk("swipe_lr", pulses * 8 + code, 8 + 1);
        swipe(1'b1, pulses, code);
        chk("swipe_rl", pulses * 8 + code, 8 + 2);

        // Hover reported once, then blocked until all far
        pulses = 0;
        code = 0;
        run_seg(70, 4000, 4000, 4000, pulses, code);
        run_seg(10, 0, 0, 0, pulses, code);
        chk("hover_once", pulses * 8 + code, 8 + 5);

        // One channel held past the timeout discards the track
        pulses = 0;
        code = 0;
        run_seg(40, 4000, 0, 0, pulses, code);
        run_seg(6, 0, 4000, 0, pulses, code);
        run_seg(10, 0, 0, 0, pulses, code);
        chk("timeout_nopulse", pulses, 0);

        // Reset mid-track, then a normal swipe
        pulses = 0;
        code = 0;
        run_seg(4, 4000, 0, 0, pulses, code);
        do_reset();
        swipe(1'b0, pulses, code);
        chk("post_reset_lr", pulses * 8 + code, 8 + 1);

        // Random segments against the model
        do_reset();
        for (int s = 0; s < 45; s++) begin
            mask = $urandom_range(0, 7);
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(30, 70)
                                              : $urandom_range(1, 8);
            pulses = 0;
            code = 0;
            for (int i = 0; i < len; i++) begin
                for (int j = 0; j < 3; j++) begin
                    if ($urandom_range(0, 15) == 0)
                        v[j] = $urandom_range(0, 65535);
                    else if (mask & (1 << j))
                        v[j] = $urandom_range(2600, 60000);
                    else
                        v[j] = $urandom_range(0, 1000);
                end
                run_seg(1, v[0], v[1], v[2], pulses, code);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
